// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings, reset/bubble values
// and the halt-opcode test.
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        FS_FETCH   = 3'd0,
        FS_WAIT    = 3'd1,
        FS_HOLD    = 3'd2,
        FS_DISCARD = 3'd3,
        FS_HALTED  = 3'd4
    } fetch_state_e;

    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [15:0] RESET_PC    = 16'h0000;

    function automatic logic isHalt(input logic [15:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+2 and a valid flag.
// Squash and reset both force the bubble encoding; squash wins over load.
module ifid_reg #(
    parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] incPc_i,
    output logic [15:0] instr_o,
    output logic [15:0] incPc_o,
    output logic        valid_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || squash_i) begin
            instr_o <= NOP_INSTR;
            incPc_o <= 16'h0000;
            valid_o <= 1'b0;
        end else if (load_i) begin
            instr_o <= instr_i;
            incPc_o <= incPc_i;
            valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory handshake, stall/redirect and the IF/ID boundary.
// Build macro FETCH_ALIGN_CHECK_EN turns an odd PC into a fetch error instead of ignoring bit 0.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [15:0] RedirectPC,
    output logic        IMemRd,
    output logic [15:0] IMemAddr,
    input  logic [15:0] IMemData,
    input  logic        IMemDone,
    input  logic        IMemErr,
    output logic [15:0] Instr,
    output logic [15:0] IncPC,
    output logic        InstrValid,
    output logic        Err
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  reqAddr_q, reqAddr_d;
    logic [15:0]  holdInstr_q, holdInstr_d;
    logic [15:0]  holdIncPc_q, holdIncPc_d;
    logic         err_q, err_d;

    logic [15:0]  pcPlus2, fetchAddr, ifidInstr, ifidIncPc;
    logic         misaligned, misalignedReq, ifidLoad, ifidSquash;

    assign pcPlus2 = pc_q + 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetchAddr  = pc_q;
    assign misaligned = pc_q[0];
`else
    assign fetchAddr  = {pc_q[15:1], 1'b0};
    assign misaligned = 1'b0;
`endif

    assign misalignedReq = (state_q == FS_FETCH) && !Stall && misaligned;

    // A read in flight keeps its original address even after a redirect has moved the PC.
    assign IMemAddr = (state_q == FS_WAIT || state_q == FS_DISCARD) ? reqAddr_q : fetchAddr;

    always_comb begin
        IMemRd = 1'b0;
        if (!rst) begin
            case (state_q)
                FS_FETCH:            IMemRd = !Stall && !Flush && !misaligned;
                FS_WAIT, FS_DISCARD: IMemRd = 1'b1;
                default:             IMemRd = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        reqAddr_d   = reqAddr_q;
        holdInstr_d = holdInstr_q;
        holdIncPc_d = holdIncPc_q;
        err_d       = err_q;
        ifidLoad    = 1'b0;
        ifidSquash  = 1'b0;
        ifidInstr   = IMemData;
        ifidIncPc   = pcPlus2;

        if (Flush) begin
            pc_d       = RedirectPC;
            ifidSquash = 1'b1;
            state_d    = (state_q == FS_WAIT && !IMemDone) ? FS_DISCARD : FS_FETCH;
        end else begin
            case (state_q)
                FS_FETCH, FS_WAIT: begin
                    if (misalignedReq) begin
                        err_d      = 1'b1;
                        ifidSquash = 1'b1;
                        state_d    = FS_HALTED;
                    end else if (state_q == FS_WAIT || !Stall) begin
                        if (!IMemDone) begin
                            state_d   = FS_WAIT;
                            reqAddr_d = IMemAddr;
                        end else if (IMemErr) begin
                            err_d      = 1'b1;
                            ifidSquash = 1'b1;
                            state_d    = FS_HALTED;
                        end else if (Stall) begin
                            // Park the word; a halt keeps the PC pointing at itself.
                            holdInstr_d = IMemData;
                            holdIncPc_d = pcPlus2;
                            if (!isHalt(IMemData)) pc_d = pcPlus2;
                            state_d = FS_HOLD;
                        end else begin
                            ifidLoad = 1'b1;
                            if (isHalt(IMemData)) begin
                                state_d = FS_HALTED;
                            end else begin
                                pc_d    = pcPlus2;
                                state_d = FS_FETCH;
                            end
                        end
                    end
                end
                FS_HOLD: begin
                    if (!Stall) begin
                        ifidLoad  = 1'b1;
                        ifidInstr = holdInstr_q;
                        ifidIncPc = holdIncPc_q;
                        state_d   = isHalt(holdInstr_q) ? FS_HALTED : FS_FETCH;
                    end
                end
                FS_DISCARD: begin
                    if (IMemDone) state_d = FS_FETCH;
                end
                FS_HALTED: ifidSquash = 1'b1;
                default:   state_d = FS_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_FETCH;
            pc_q        <= RESET_PC;
            reqAddr_q   <= 16'h0000;
            holdInstr_q <= NOP_INSTR;
            holdIncPc_q <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            reqAddr_q   <= reqAddr_d;
            holdInstr_q <= holdInstr_d;
            holdIncPc_q <= holdIncPc_d;
            err_q       <= err_d;
        end
    end

    assign Err = err_q;

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (ifidLoad),
        .squash_i(ifidSquash),
        .instr_i (ifidInstr),
        .incPc_i (ifidIncPc),
        .instr_o (Instr),
        .incPc_o (IncPC),
        .valid_o (InstrValid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized stall/flush/latency
// traffic, all checked against a flag-based behavioural model of the fetch unit.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst, Stall, Flush, IMemDone, IMemErr;
    logic [15:0] RedirectPC, IMemData;
    logic        IMemRd, InstrValid, Err;
    logic [15:0] IMemAddr, Instr, IncPC;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Stall     (Stall),
        .Flush     (Flush),
        .RedirectPC(RedirectPC),
        .IMemRd    (IMemRd),
        .IMemAddr  (IMemAddr),
        .IMemData  (IMemData),
        .IMemDone  (IMemDone),
        .IMemErr   (IMemErr),
        .Instr     (Instr),
        .IncPC     (IncPC),
        .InstrValid(InstrValid),
        .Err       (Err)
    );

    int checkCount = 0;
    int errorCount = 0;

    // Instruction memory environment: word array plus a latency counter per request.
    logic [15:0] mem [0:32767];
    bit          memBusy;
    int          memCount;
    logic [15:0] memAddr;
    int          nextLat;
    int          errPct;

    // Reference model: a PC, whether a read is outstanding (1 = live, 2 = to be dropped),
    // a parked word, a halted flag, and the expected IF/ID contents.
    logic [15:0] mPc, mReqAddr, mBufWord, mBufInc, mInstr, mInc;
    int          mReading;
    bit          mBufValid, mHalted, mValid, mErr;

    logic        obsRd;
    logic [15:0] obsAddr;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic bit modelMisaligned(input logic [15:0] pc);
`ifdef FETCH_ALIGN_CHECK_EN
        return pc[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] alignedPc(input logic [15:0] pc);
`ifdef FETCH_ALIGN_CHECK_EN
        return pc;
`else
        return pc & 16'hFFFE;
`endif
    endfunction

    function automatic logic modelRd();
        if (rst) return 1'b0;
        if (mReading != 0) return 1'b1;
        if (mBufValid || mHalted) return 1'b0;
        return !Stall && !Flush && !modelMisaligned(mPc);
    endfunction

    task automatic squashModel();
        mInstr = NOP;
        mInc   = 16'h0000;
        mValid = 1'b0;
    endtask

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic modelStep();
        bit halt;
        halt = (IMemData[15:11] == 5'b00000);
        if (rst) begin
            mPc = 16'h0000; mReading = 0; mBufValid = 0; mHalted = 0; mErr = 0;
            squashModel();
        end else if (Flush) begin
            mPc       = RedirectPC;
            mReading  = (mReading == 1 && !IMemDone) ? 2 : 0;
            mBufValid = 0;
            mHalted   = 0;
            squashModel();
        end else if (mHalted) begin
            squashModel();
        end else if (mReading == 2) begin
            if (IMemDone) mReading = 0;
        end else if (mBufValid) begin
            if (!Stall) begin
                mInstr    = mBufWord;
                mInc      = mBufInc;
                mValid    = 1'b1;
                mBufValid = 0;
                mHalted   = (mBufWord[15:11] == 5'b00000);
            end
        end else if (mReading == 0 && Stall) begin
            mReading = 0;
        end else if (mReading == 0 && modelMisaligned(mPc)) begin
            mErr = 1'b1; mHalted = 1'b1;
            squashModel();
        end else if (!IMemDone) begin
            if (mReading == 0) mReqAddr = alignedPc(mPc);
            mReading = 1;
        end else begin
            mReading = 0;
            if (IMemErr) begin
                mErr = 1'b1; mHalted = 1'b1;
                squashModel();
            end else if (Stall) begin
                mBufWord  = IMemData;
                mBufInc   = mPc + 16'd2;
                mBufValid = 1'b1;
                if (!halt) mPc = mPc + 16'd2;
            end else begin
                mInstr = IMemData;
                mInc   = mPc + 16'd2;
                mValid = 1'b1;
                if (halt) mHalted = 1'b1;
                else      mPc = mPc + 16'd2;
            end
        end
    endtask

    // Memory answers the request the DUT is actually presenting.
    task automatic memRespond();
        if (!IMemRd) begin
            memBusy = 0;
        end else begin
            if (!memBusy || memAddr != IMemAddr) begin
                memBusy  = 1;
                memAddr  = IMemAddr;
                memCount = nextLat;
            end
            if (memCount == 0) begin
                IMemDone = 1'b1;
                IMemData = mem[memAddr[15:1]];
                IMemErr  = ($urandom_range(0, 99) < errPct);
                memBusy  = 0;
            end else begin
                memCount--;
            end
        end
    endtask

    // One clock cycle: drive inputs, check the request side, let memory answer, clock, check IF/ID.
    task automatic applyStimulus(input logic r, input logic st, input logic fl, input logic [15:0] redir);
        logic expRd;
        rst = r; Stall = st; Flush = fl; RedirectPC = redir;
        IMemDone = 1'b0; IMemErr = 1'b0; IMemData = 16'($urandom);
        #1;
        obsRd   = IMemRd;
        obsAddr = IMemAddr;
        expRd   = modelRd();
        checkOutput("IMemRd", {15'b0, obsRd}, {15'b0, expRd});
        if (expRd) checkOutput("IMemAddr", obsAddr, (mReading != 0) ? mReqAddr : alignedPc(mPc));
        memRespond();
        #1;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("Instr", Instr, mInstr);
        checkOutput("IncPC", IncPC, mInc);
        checkOutput("InstrValid", {15'b0, InstrValid}, {15'b0, mValid});
        checkOutput("Err", {15'b0, Err}, {15'b0, mErr});
    endtask

    initial begin
        logic [15:0] w;
        logic        r, st, fl;
        logic [15:0] rd;

        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 19) == 0) w[15:11] = 5'b00000;
            else if (w[15:11] == 5'b00000) w[15] = 1'b1;
            mem[i] = w;
        end
        memBusy = 0; memCount = 0; memAddr = 16'h0000;
        nextLat = 0; errPct = 0;
        mPc = 0; mReqAddr = 0; mBufWord = 0; mBufInc = 0; mReading = 0;
        mBufValid = 0; mHalted = 0; mErr = 0;
        squashModel();

        // Single-cycle memory, back-to-back fetches.
        mem[0] = 16'hC001; mem[1] = 16'hC002; mem[2] = 16'hC003;
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("rstInstr", Instr, 16'h0800);
        checkOutput("rstIncPC", IncPC, 16'h0000);
        checkOutput("rstValid", {15'b0, InstrValid}, 16'h0000);
        checkOutput("rstErr", {15'b0, Err}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("seqAddr0", obsAddr, 16'h0000);
        checkOutput("seqInstr0", Instr, 16'hC001);
        checkOutput("seqInc0", IncPC, 16'h0002);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("seqAddr1", obsAddr, 16'h0002);
        checkOutput("seqInstr1", Instr, 16'hC002);
        checkOutput("seqInc1", IncPC, 16'h0004);
        checkOutput("seqValid1", {15'b0, InstrValid}, 16'h0001);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("seqAddr2", obsAddr, 16'h0004);

        // Three-cycle memory with a stall on the Done cycle.
        mem[0] = 16'hA5A5;
        applyStimulus(1, 0, 0, 16'h0000);
        nextLat = 2;
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("slowAddrA", obsAddr, 16'h0000);
        checkOutput("slowValidA", {15'b0, InstrValid}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("slowAddrB", obsAddr, 16'h0000);
        applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("slowAddrC", obsAddr, 16'h0000);
        checkOutput("holdValid", {15'b0, InstrValid}, 16'h0000);
        nextLat = 0;
        applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("holdRd", {15'b0, obsRd}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("holdInstr", Instr, 16'hA5A5);
        checkOutput("holdInc", IncPC, 16'h0002);

        // Flush together with Stall in FETCH.
        applyStimulus(0, 1, 1, 16'h0040);
        checkOutput("flushInstr", Instr, 16'h0800);
        checkOutput("flushValid", {15'b0, InstrValid}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("flushAddr", obsAddr, 16'h0040);

        // Flush while a slow read is outstanding: the stale word must be dropped.
        mem[16'h0042 >> 1] = 16'hBEEF;
        mem[16'h0100 >> 1] = 16'h1234;
        nextLat = 2;
        applyStimulus(0, 0, 0, 16'h0000);
        nextLat = 0;
        applyStimulus(0, 0, 1, 16'h0100);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("discardAddr", obsAddr, 16'h0042);
        checkOutput("discardValid", {15'b0, InstrValid}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("redirAddr", obsAddr, 16'h0100);
        checkOutput("redirInstr", Instr, 16'h1234);
        checkOutput("redirInc", IncPC, 16'h0102);

        // Halt opcode at PC 6.
        mem[0] = 16'h8001; mem[1] = 16'h8002; mem[2] = 16'h8003; mem[3] = 16'h0000;
        applyStimulus(1, 0, 0, 16'h0000);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("haltInstr", Instr, 16'h0000);
        checkOutput("haltInc", IncPC, 16'h0008);
        checkOutput("haltValid", {15'b0, InstrValid}, 16'h0001);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("haltRd0", {15'b0, obsRd}, 16'h0000);
        checkOutput("haltNop", Instr, 16'h0800);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("haltRd1", {15'b0, obsRd}, 16'h0000);
        applyStimulus(0, 0, 1, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("haltExitRd", {15'b0, obsRd}, 16'h0001);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect target raises a sticky error.
        applyStimulus(0, 0, 1, 16'h0011);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("alignRd", {15'b0, obsRd}, 16'h0000);
        checkOutput("alignErr", {15'b0, Err}, 16'h0001);
        applyStimulus(0, 0, 1, 16'h0020);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("alignSticky", {15'b0, Err}, 16'h0001);
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("alignClear", {15'b0, Err}, 16'h0000);
`endif

        // Randomized traffic, including wrap-around and odd redirect targets.
        errPct = 2;
        for (int c = 0; c < 4000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = mHalted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 15))
                0:       rd = 16'hFFFE;
                1:       rd = 16'($urandom) | 16'h0001;
                default: rd = 16'($urandom) & 16'hFFFE;
            endcase
            nextLat = $urandom_range(0, 3);
            applyStimulus(r, st, fl, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage pipeline. It holds the PC, drives the instruction-memory read port, and absorbs multi-cycle memory latency. It also applies stall and flush/redirect from the hazard and branch logic. Its registered outputs (`Instr`, `IncPC`, `InstrValid`) form the IF/ID boundary and feed the decode stage directly.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0800, bubble encoding placed in IF/ID.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1, sole clock.
- `rst` in 1, synchronous, active-high reset.
- `Stall` in 1, hazard unit request to hold PC and IF/ID.
- `Flush` in 1, redirect request: squash IF/ID and load `RedirectPC`.
- `RedirectPC` in 16, branch/jump/rti target, sampled when `Flush`=1.
- `IMemRd` out 1, instruction read request.
- `IMemAddr` out 16, read address; equals PC.
- `IMemData` in 16, read data, valid only while `IMemDone`=1.
- `IMemDone` in 1, read complete (may rise the same cycle as `IMemRd`).
- `IMemErr` in 1, memory fault on the current read.
- `Instr` out 16, IF/ID instruction.
- `IncPC` out 16, IF/ID PC+2 of `Instr`.
- `InstrValid` out 1, IF/ID holds a real instruction.
- `Err` out 1, sticky fetch error.

## Operation
The state machine has five states: FETCH, WAIT, HOLD, DISCARD, HALTED.

- **FETCH**
  - `IMemRd`=1 when `!Stall && !Flush`.
  - Done same cycle: load IF/ID with `IMemData`, `PC+2`, valid=1; PC←PC+2; stay in FETCH.
  - No Done: go to WAIT.
- **WAIT**
  - `IMemRd` and `IMemAddr` stay constant until Done.
  - Done with `!Stall`: load IF/ID, PC←PC+2, go to FETCH.
  - Done with `Stall`: capture the data in the hold buffer, PC←PC+2, go to HOLD.
- **HOLD**
  - `IMemRd`=0.
  - On the first `!Stall` cycle: move the buffer into IF/ID, go to FETCH.
- **DISCARD**
  - Entered on `Flush` while WAIT has a read in flight.
  - `IMemRd` stays 1 at the old address.
  - On Done: drop the data, go to FETCH; PC already equals `RedirectPC`.
- **HALTED**
  - Entered when an instruction with opcode `Instr[15:11]`=5'b00000 is loaded into IF/ID. PC is not advanced past it.
  - `IMemRd`=0.
  - IF/ID shows the halt for one cycle, then becomes NOP/invalid.
  - Leaves only on `Flush`, going to FETCH.

Stall and Flush:
- `Stall` with no Flush: PC and IF/ID hold their values.
- `Flush` has priority over `Stall` and over Done in every state.
  - PC←`RedirectPC`; IF/ID←`NOP_INSTR`, `IncPC`=0, valid=0.
  - The hold buffer is dropped.
  - Next state: DISCARD if in WAIT with no Done that cycle, otherwise FETCH.

Arithmetic and errors:
- PC arithmetic is 16-bit and wraps: 16'hFFFE+2 = 16'h0000, no error.
- `IMemErr` with Done sets `Err`. The word is loaded as `NOP_INSTR` with valid=0, then the stage goes to HALTED.
- `Err` clears only on `rst`.

## Timing
Reset values:
- PC=`RESET_PC`, state FETCH.
- `Instr`=`NOP_INSTR`, `IncPC`=0, `InstrValid`=0, `Err`=0.
- `IMemRd`=0 during any cycle with `rst`=1.

Latency and throughput:
- With single-cycle memory (Done the same cycle as Rd), the instruction at PC appears in IF/ID one cycle after the request cycle. Throughput is one instruction per cycle.
- With N-cycle memory, throughput is one instruction per N cycles.
- Redirect: the first `RedirectPC` request is the cycle after `Flush` (FETCH case). In the DISCARD case it follows the stale Done.
- `Stall` and `Flush` are sampled on the same edge as the state update. IF/ID changes only at `clk` edges.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A PC with bit 0 = 1 at request time suppresses `IMemRd`.
  - It sets `Err`, loads `NOP_INSTR` with valid=0, and enters HALTED.
- Undefined:
  - PC bit 0 is ignored.
  - `IMemAddr` = {PC[15:1],1'b0}.
  - No alignment error is raised.

## Structure
- Shared package holds:
  - state encodings `FS_FETCH`, `FS_WAIT`, `FS_HOLD`, `FS_DISCARD`, `FS_HALTED`;
  - `NOP_INSTR`;
  - `HALT_OPCODE`=5'b00000;
  - `RESET_PC`.
- One sub-module, `ifid_reg`: the IF/ID register (`Instr`, `IncPC`, `InstrValid`) with load, hold and squash controls and a synchronous reset to the NOP values.

## Test plan
- Reset then single-cycle memory returning 16'hC001, 16'hC002: `IMemAddr` sequence 0, 2, 4. `Instr` is 16'hC001 with `IncPC`=2, then 16'hC002 with `IncPC`=4, `InstrValid`=1.
- Memory with 3-cycle Done: `IMemAddr` holds at 0 for 3 cycles and `InstrValid` stays 0 until the Done edge. Stall on the Done cycle → HOLD; the instruction appears on the first cycle after `Stall` drops.
- `Flush`, `RedirectPC`=16'h0040, and `Stall` together in FETCH: IF/ID becomes 16'h0800 with valid=0 and the next `IMemAddr`=16'h0040.
- `Flush` to 16'h0100 during WAIT: the stale Done data is never loaded. The first loaded instruction has `IncPC`=16'h0102.
- Memory returns 16'h0000 at PC 6: IF/ID shows the halt with `IncPC`=8, then NOP. `IMemRd` stays 0 until `Flush`.
- `FETCH_ALIGN_CHECK_EN` set with `Flush` to 16'h0011: `IMemRd` stays 0, `Err`=1 the next cycle and remains set until `rst`.
